// File: rtl/sp_ram_fifo_ctrl.sv
// FIFO controller owning the single port of single_port_ram: arbitrates write/read
// on that port and stages the RAM's registered q into a 2-entry output queue.
module sp_ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_enable,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] MEM_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {
    GRANT_WRITE,
    GRANT_READ
  } grant_t;

  logic [ADDR_WIDTH-1:0] r_wrPtr;
  logic [ADDR_WIDTH-1:0] r_rdPtr;
  logic [ADDR_WIDTH:0]   r_memCnt;
  logic                  r_rdPend;
  logic [1:0]            r_outOcc;
  grant_t                r_lastGrant;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;

  logic       w_credit;
  logic       w_wantRd;
  logic       w_inReady;
  logic       w_wrG;
  logic       w_rdG;
  logic       w_pop;
  logic [2:0] w_occSum;

  // Read credit counts the in-flight word so the queue can never overflow;
  // a pop in the same cycle deliberately gives no credit.
  assign w_occSum  = {1'b0, r_outOcc} + {2'b00, r_rdPend};
  assign w_credit  = (w_occSum < 3'd2);
  assign w_wantRd  = (r_memCnt != '0) && w_credit;
  assign w_inReady = (r_memCnt != MEM_FULL) && !(w_wantRd && (r_lastGrant == GRANT_WRITE));
  assign w_wrG     = in_valid && w_inReady;
  assign w_rdG     = w_wantRd && !w_wrG;
  assign w_pop     = (r_outOcc != 2'd0) && out_ready;

  assign in_ready   = w_inReady;
  assign ram_data   = in_data;
  assign ram_enable = w_wrG;
  assign ram_addr   = w_wrG ? r_wrPtr : r_rdPtr;

  assign out_valid = (r_outOcc != 2'd0);
  assign out_data  = r_head;
  assign full      = (r_memCnt == MEM_FULL);
  assign count     = (ADDR_WIDTH + 2)'(r_memCnt) + (ADDR_WIDTH + 2)'(r_rdPend)
                   + (ADDR_WIDTH + 2)'(r_outOcc);
  assign empty     = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_memCnt    <= '0;
      r_rdPend    <= 1'b0;
      r_outOcc    <= 2'd0;
      r_lastGrant <= GRANT_READ;
      r_head      <= '0;
      r_tail      <= '0;
    end else begin
      if (w_wrG) begin
        r_wrPtr     <= r_wrPtr + 1'b1;
        r_memCnt    <= r_memCnt + 1'b1;
        r_lastGrant <= GRANT_WRITE;
      end else if (w_rdG) begin
        r_rdPtr     <= r_rdPtr + 1'b1;
        r_memCnt    <= r_memCnt - 1'b1;
        r_lastGrant <= GRANT_READ;
      end
      r_rdPend <= w_rdG;

      // Head always holds the oldest word; tail is only used at occupancy 2.
      case ({r_rdPend, w_pop})
        2'b10: begin
          if (r_outOcc == 2'd0) r_head <= ram_q;
          else                  r_tail <= ram_q;
          r_outOcc <= r_outOcc + 2'd1;
        end
        2'b01: begin
          r_head   <= r_tail;
          r_outOcc <= r_outOcc - 2'd1;
        end
        2'b11: begin
          if (r_outOcc == 2'd1) begin
            r_head <= ram_q;
          end else begin
            r_head <= r_tail;
            r_tail <= ram_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Self-checking bench for sp_ram_fifo_ctrl: behavioural RAM plus a word-order
// scoreboard (accepted sequence vs popped sequence) and occupancy arithmetic.
module tb_sp_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [7:0] count;
  logic       full;
  logic       empty;
  logic [7:0] ram_data;
  logic [5:0] ram_addr;
  logic       ram_enable;
  logic [7:0] ram_q;

  logic [7:0] ramMem [64];

  int nChecks = 0;
  int nFails  = 0;

  logic [7:0] acceptedQ [$];
  int         nAcc;
  int         nPop;
  logic       tAcc;
  logic       tPop;
  logic       tEn;
  logic [7:0] tPopData;
  logic [7:0] tInData;
  int         tPopIdx;

  sp_ram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .ram_data   (ram_data),
    .ram_addr   (ram_addr),
    .ram_enable (ram_enable),
    .ram_q      (ram_q)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: write when enabled, otherwise registered read.
  always @(posedge clk) begin
    if (ram_enable) ramMem[ram_addr] <= ram_data;
    else            ram_q <= ramMem[ram_addr];
  end

  task automatic clearModel();
    acceptedQ.delete();
    nAcc = 0;
    nPop = 0;
  endtask

  // Advances one clock, recording the handshakes that occur at that edge.
  task automatic tick();
    @(negedge clk);
    tAcc     = in_valid && in_ready;
    tPop     = out_valid && out_ready;
    tPopData = out_data;
    tInData  = in_data;
    tEn      = ram_enable;
    tPopIdx  = nPop;
    @(posedge clk);
    if (tAcc) begin
      acceptedQ.push_back(tInData);
      nAcc++;
    end
    if (tPop) nPop++;
    #1;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    clearModel();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    nChecks++;
    if (count !== 8'd0) begin nFails++; $display("[TB] FAIL reset_count got=%0d want=0", count); end
    nChecks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      nFails++; $display("[TB] FAIL reset_flags got empty=%b full=%b want empty=1 full=0", empty, full);
    end
    nChecks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      nFails++; $display("[TB] FAIL reset_out got valid=%b data=%h want valid=0 data=00", out_valid, out_data);
    end
    nChecks++;
    if (in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_reset_mid_stream();
    int guard;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h40;
    guard     = 0;
    while (nAcc < 12 && guard < 60) begin
      tick();
      if (tAcc) in_data = in_data + 8'd1;
      guard++;
    end
    in_valid = 1'b0;
    repeat (6) tick();
    nChecks++;
    if (count !== 8'(nAcc - nPop) || nAcc != 12) begin
      nFails++; $display("[TB] FAIL midreset_preload got count=%0d acc=%0d want=12", count, nAcc);
    end
    rst_n = 1'b0;
    clearModel();
    #1;
    nChecks++;
    if (out_valid !== 1'b0 || count !== 8'd0 || empty !== 1'b1 || full !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL midreset_async got valid=%b count=%0d empty=%b full=%b want 0/0/1/0",
               out_valid, count, empty, full);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    nChecks++;
    if (in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL midreset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_single_word();
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    out_ready = 1'b1;
    #1;
    nChecks++;
    if (ram_enable !== 1'b1 || ram_addr !== 6'd0 || ram_data !== 8'hA5) begin
      nFails++; $display("[TB] FAIL single_e0 got en=%b addr=%0d data=%h want en=1 addr=0 data=a5",
                         ram_enable, ram_addr, ram_data);
    end
    tick();
    in_valid = 1'b0;
    #1;
    nChecks++;
    if (ram_enable !== 1'b0 || ram_addr !== 6'd0 || out_valid !== 1'b0) begin
      nFails++; $display("[TB] FAIL single_e1 got en=%b addr=%0d valid=%b want en=0 addr=0 valid=0",
                         ram_enable, ram_addr, out_valid);
    end
    tick();
    nChecks++;
    if (out_valid !== 1'b0 || count !== 8'd1) begin
      nFails++; $display("[TB] FAIL single_inflight got valid=%b count=%0d want valid=0 count=1", out_valid, count);
    end
    tick();
    nChecks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      nFails++; $display("[TB] FAIL single_e2 got valid=%b data=%h want valid=1 data=a5", out_valid, out_data);
    end
    tick();
    nChecks++;
    if (!tPop || count !== 8'd0 || empty !== 1'b1) begin
      nFails++; $display("[TB] FAIL single_pop got popped=%b count=%0d empty=%b want 1/0/1", tPop, count, empty);
    end
  endtask

  task automatic test_fill();
    doReset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tAcc) in_data = in_data + 8'd1;
    end
    nChecks++;
    if (nAcc != 66 || in_ready !== 1'b0 || full !== 1'b1 || count !== 8'd66) begin
      nFails++; $display("[TB] FAIL fill_capacity got acc=%0d ready=%b full=%b count=%0d want 66/0/1/66",
                         nAcc, in_ready, full, count);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (tPop) begin
        nChecks++;
        if (tPopData !== 8'(tPopIdx)) begin
          nFails++; $display("[TB] FAIL fill_order idx=%0d got=%0d want=%0d", tPopIdx, tPopData, tPopIdx);
        end
      end
    end
    nChecks++;
    if (nPop != 66 || count !== 8'd0) begin
      nFails++; $display("[TB] FAIL fill_drain got pops=%0d count=%0d want 66/0", nPop, count);
    end
  endtask

  task automatic test_contention();
    int  guard;
    logic prevEn;
    doReset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'($urandom);
    guard     = 0;
    while (nAcc < 10 && guard < 60) begin
      tick();
      if (tAcc) in_data = 8'($urandom);
      guard++;
    end
    in_valid = 1'b0;
    repeat (4) tick();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    prevEn    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (tAcc) in_data = 8'($urandom);
      if (i > 0) begin
        nChecks++;
        if (tEn === prevEn) begin
          nFails++; $display("[TB] FAIL contention_alternate cycle=%0d got en=%b prev=%b want differ", i, tEn, prevEn);
        end
      end
      prevEn = tEn;
      if (tPop) begin
        nChecks++;
        if (tPopData !== acceptedQ[tPopIdx]) begin
          nFails++; $display("[TB] FAIL contention_data idx=%0d got=%h want=%h", tPopIdx, tPopData, acceptedQ[tPopIdx]);
        end
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tPop) begin
        nChecks++;
        if (tPopData !== acceptedQ[tPopIdx]) begin
          nFails++; $display("[TB] FAIL contention_drain idx=%0d got=%h want=%h", tPopIdx, tPopData, acceptedQ[tPopIdx]);
        end
      end
    end
    nChecks++;
    if (count !== 8'd0 || nPop != nAcc) begin
      nFails++; $display("[TB] FAIL contention_end got count=%0d pops=%0d want 0/%0d", count, nPop, nAcc);
    end
  endtask

  task automatic test_wrap();
    int nextVal;
    int cycles;
    doReset();
    nextVal = 0;
    cycles  = 0;
    in_data = 8'd0;
    while (nPop < 200 && cycles < 4000) begin
      in_valid  = (nextVal < 200) && ($urandom_range(0, 99) >= 30);
      out_ready = ($urandom_range(0, 99) >= 30);
      tick();
      cycles++;
      if (tAcc) begin
        nextVal++;
        in_data = 8'(nextVal);
      end
      if (tPop) begin
        nChecks++;
        if (tPopIdx >= 200 || tPopData !== 8'(tPopIdx)) begin
          nFails++; $display("[TB] FAIL wrap_order idx=%0d got=%0d want=%0d", tPopIdx, tPopData, tPopIdx);
        end
      end
      nChecks++;
      if (count !== 8'(nAcc - nPop) || empty !== (nAcc == nPop) || (full && in_ready)) begin
        nFails++; $display("[TB] FAIL wrap_count got count=%0d empty=%b full=%b ready=%b want count=%0d",
                           count, empty, full, in_ready, nAcc - nPop);
      end
    end
    in_valid = 1'b0;
    nChecks++;
    if (nPop != 200 || nAcc != 200) begin
      nFails++; $display("[TB] FAIL wrap_complete got acc=%0d pops=%0d want 200/200", nAcc, nPop);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] words [3];
    int guard;
    words[0] = 8'h3C;
    words[1] = 8'h11;
    words[2] = 8'h22;
    doReset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      guard    = 0;
      tick();
      while (!tAcc && guard < 10) begin
        tick();
        guard++;
      end
    end
    in_valid = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      nChecks++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || count !== 8'd3) begin
        nFails++; $display("[TB] FAIL backpressure_hold cycle=%0d got valid=%b data=%h count=%0d want 1/3c/3",
                           i, out_valid, out_data, count);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tPop) begin
        nChecks++;
        if (tPopIdx > 2 || tPopData !== words[tPopIdx]) begin
          nFails++; $display("[TB] FAIL backpressure_drain idx=%0d got=%h", tPopIdx, tPopData);
        end
      end
    end
    nChecks++;
    if (nPop != 3 || empty !== 1'b1) begin
      nFails++; $display("[TB] FAIL backpressure_end got pops=%0d empty=%b want 3/1", nPop, empty);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    clearModel();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_reset_mid_stream();
    test_single_word();
    test_fill();
    test_contention();
    test_wrap();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
